adc_idelay_cal: RTL and testbench

- Calibration controller for the ADC DDR capture path: sweeps the shared IODELAYE1 (VARIABLE mode) tap on the ADC data lines while the ADC outputs a fixed test pattern.
- Checks the captured I/Q words at every tap, finds the widest contiguous passing window and parks the delay at its centre.
- Sits between the ADC capture block outputs (clk_ext domain; this block runs on that clock) and the IODELAY CE/INC/RST controls; started by host logic after the ADC is put in test-pattern mode.

---
 rtl/adc_idelay_cal_if.sv | 31 +++
 rtl/adc_idelay_cal.sv | 221 ++++++++++++++++++++++
 tb/tb_adc_idelay_cal.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_idelay_cal_if.sv
// Signal bundle of the IODELAY calibration controller: host start/status,
// captured ADC I/Q words and the IODELAY tap control pulses.
interface adc_idelay_cal_if #(
  parameter int NUM_TAPS = 32
);
  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int LEN_W = TAP_W + 1;

  logic             start;
  logic [15:0]      adc_i;
  logic [15:0]      adc_q;
  logic             dly_rst;
  logic             dly_ce;
  logic             dly_inc;
  logic             busy;
  logic             done;
  logic             fail;
  logic [TAP_W-1:0] tap_value;
  logic [TAP_W-1:0] win_start;
  logic [LEN_W-1:0] win_len;

  modport master (
    output start, adc_i, adc_q,
    input  dly_rst, dly_ce, dly_inc, busy, done, fail, tap_value, win_start, win_len
  );

  modport slave (
    input  start, adc_i, adc_q,
    output dly_rst, dly_ce, dly_inc, busy, done, fail, tap_value, win_start, win_len
  );
endinterface

// File: rtl/adc_idelay_cal.sv
// Sweeps the shared ADC-data IODELAY tap against a fixed test pattern, finds the
// widest contiguous passing window and parks the delay at its centre.
module adc_idelay_cal #(
  parameter int          NUM_TAPS      = 32,
  parameter int          SETTLE_CYCLES = 16,
  parameter int          SAMPLE_COUNT  = 256,
  parameter int          MIN_WINDOW    = 4,
  parameter logic [15:0] PAT_I         = 16'h1555,
  parameter logic [15:0] PAT_Q         = 16'h2AAA
) (
  input  logic              clk,
  input  logic              rst,
  adc_idelay_cal_if.slave   bus
);

  localparam int TAP_W   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int LEN_W   = TAP_W + 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] MIN_LEN     = LEN_W'(MIN_WINDOW);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_COUNT - 1);

  typedef enum logic [3:0] {
    IDLE, DRST, SETTLE, CHECK, STEP, EVAL, CRST, MOVE, DONE, FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic [TAP_W-1:0] cur_start_q, cur_start_d;
  logic [LEN_W-1:0] best_len_q, best_len_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [TAP_W-1:0] target_q, target_d;
  logic             win_ok_q, win_ok_d;
  logic [TAP_W-1:0] win_start_q, win_start_d;
  logic [LEN_W-1:0] win_len_q, win_len_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;

  logic             sample_ok;
  logic             tap_pass;
  logic [LEN_W-1:0] cur_len_inc;
  logic             dly_rst_o;
  logic             dly_ce_o;
  logic             busy_o;

  assign sample_ok   = (bus.adc_i == PAT_I) && (bus.adc_q == PAT_Q);
  assign tap_pass    = ~err_q & sample_ok;
  assign cur_len_inc = cur_len_q + LEN_ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = DRST;
      DRST:    state_d = SETTLE;
      SETTLE:  if (cnt_q == SETTLE_LAST) state_d = CHECK;
      CHECK:   if (cnt_q == SAMPLE_LAST) state_d = (tap_q == LAST_TAP) ? EVAL : STEP;
      STEP:    state_d = SETTLE;
      EVAL:    state_d = CRST;
      CRST: begin
        if (target_q != '0) state_d = MOVE;
        else                state_d = win_ok_q ? DONE : FAIL;
      end
      // Odd count is the gap cycle after a pulse; tap already reflects that pulse.
      MOVE:    if (cnt_q[0] && (tap_q == target_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dly_rst_o = 1'b0;
    dly_ce_o  = 1'b0;
    busy_o    = 1'b1;
    unique case (state_q)
      IDLE, DONE, FAIL: busy_o    = 1'b0;
      DRST, CRST:       dly_rst_o = 1'b1;
      STEP:             dly_ce_o  = 1'b1;
      MOVE:             dly_ce_o  = ~cnt_q[0];
      default:          ;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    err_d        = err_q;
    tap_d        = tap_q;
    cur_len_d    = cur_len_q;
    cur_start_d  = cur_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    target_d     = target_q;
    win_ok_d     = win_ok_q;
    win_start_d  = win_start_q;
    win_len_d    = win_len_q;
    done_d       = done_q;
    fail_d       = fail_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          done_d       = 1'b0;
          fail_d       = 1'b0;
          win_start_d  = '0;
          win_len_d    = '0;
          cur_len_d    = '0;
          cur_start_d  = '0;
          best_len_d   = '0;
          best_start_d = '0;
          target_d     = '0;
          win_ok_d     = 1'b0;
        end
      end
      DRST, CRST: begin
        tap_d = '0;
        cnt_d = '0;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          err_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CHECK: begin
        err_d = err_q | ~sample_ok;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d = '0;
          // Strict compare keeps the earliest of equally wide windows.
          if (tap_pass) begin
            cur_len_d = cur_len_inc;
            if (cur_len_inc > best_len_q) begin
              best_len_d   = cur_len_inc;
              best_start_d = cur_start_q;
            end
          end else begin
            cur_len_d   = '0;
            cur_start_d = tap_q + TAP_ONE;
          end
        end
      end
      STEP: tap_d = tap_q + TAP_ONE;
      EVAL: begin
        win_start_d = best_start_q;
        win_len_d   = best_len_q;
        win_ok_d    = (best_len_q >= MIN_LEN);
        target_d    = (best_len_q >= MIN_LEN) ?
                      best_start_q + TAP_W'((best_len_q - LEN_ONE) >> 1) : '0;
      end
      MOVE: begin
        cnt_d = cnt_q ^ CNT_ONE;
        if (!cnt_q[0]) tap_d = tap_q + TAP_ONE;
      end
      FAIL:    tap_d = '0;
      default: ;
    endcase
    if (state_d == DONE) done_d = 1'b1;
    if (state_d == FAIL) fail_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      err_q        <= 1'b0;
      tap_q        <= '0;
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      target_q     <= '0;
      win_ok_q     <= 1'b0;
      win_start_q  <= '0;
      win_len_q    <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      tap_q        <= tap_d;
      cur_len_q    <= cur_len_d;
      cur_start_q  <= cur_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      target_q     <= target_d;
      win_ok_q     <= win_ok_d;
      win_start_q  <= win_start_d;
      win_len_q    <= win_len_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.dly_rst   = dly_rst_o;
  assign bus.dly_ce    = dly_ce_o;
  assign bus.dly_inc   = dly_ce_o;
  assign bus.busy      = busy_o;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.tap_value = tap_q;
  assign bus.win_start = win_start_q;
  assign bus.win_len   = win_len_q;

endmodule

// File: tb/tb_adc_idelay_cal.sv
// Directed bench: an IODELAY + ADC model returns the test pattern only on chosen
// taps; each calibration result is compared against hand-computed values.
module tb_adc_idelay_cal;

  localparam int          NUM_TAPS   = 32;
  localparam int          SETTLE     = 4;
  localparam int          SAMPLES    = 8;
  localparam int          MIN_WIN    = 4;
  localparam logic [15:0] PAT_I      = 16'h1555;
  localparam logic [15:0] PAT_Q      = 16'h2AAA;
  localparam int          SWEEP_LAT  = 2 + NUM_TAPS * (SETTLE + SAMPLES) + (NUM_TAPS - 1);
  localparam int          GLITCH_TAP = 12;
  localparam int          GLITCH_AGE = 8;

  typedef struct {
    logic [31:0] mask;
    bit          glitch;
    bit          exp_done;
    bit          exp_fail;
    int          exp_ws;
    int          exp_wl;
    int          exp_tap;
    int          exp_moves;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  adc_idelay_cal_if #(.NUM_TAPS(NUM_TAPS)) bus ();

  adc_idelay_cal #(
    .NUM_TAPS(NUM_TAPS), .SETTLE_CYCLES(SETTLE), .SAMPLE_COUNT(SAMPLES),
    .MIN_WINDOW(MIN_WIN), .PAT_I(PAT_I), .PAT_Q(PAT_Q)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] pass_mask = '0;
  bit          glitch_en = 1'b0;
  int model_tap = 0, age = 0, cycle = 0;
  int ce_after_rst = 0, rst_pulses = 0, pulse_total = 0, proto_err = 0;
  int last_rst_cycle = 0, prev_rst_cycle = 0;

  // IODELAY model reacts to the pulses seen this cycle, then presents the next sample.
  always @(negedge clk) begin
    bit tap_ok;
    cycle++;
    if (bus.dly_rst && bus.dly_ce) proto_err++;
    if (bus.dly_inc !== bus.dly_ce) proto_err++;
    if (bus.dly_rst) begin
      model_tap = 0; age = 0; ce_after_rst = 0;
      rst_pulses++; pulse_total++;
      prev_rst_cycle = last_rst_cycle; last_rst_cycle = cycle;
    end else if (bus.dly_ce) begin
      model_tap++; age = 0; ce_after_rst++; pulse_total++;
    end else begin
      age++;
    end
    tap_ok = (model_tap < NUM_TAPS) && pass_mask[model_tap];
    bus.adc_i = PAT_I;
    bus.adc_q = PAT_Q;
    if (!tap_ok) begin
      if (model_tap[0]) bus.adc_i = PAT_I ^ 16'h0100;
      else              bus.adc_q = PAT_Q ^ 16'h8000;
    end else if (glitch_en && model_tap == GLITCH_TAP && age == GLITCH_AGE) begin
      bus.adc_q = PAT_Q ^ 16'h0001;
    end
  end

  function automatic logic [31:0] range_mask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int b = lo; b <= hi; b++) m[b] = 1'b1;
    return m;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "/busy"},      bus.busy,      0);
    check_output({tag, "/done"},      bus.done,      0);
    check_output({tag, "/fail"},      bus.fail,      0);
    check_output({tag, "/tap_value"}, bus.tap_value, 0);
    check_output({tag, "/win_start"}, bus.win_start, 0);
    check_output({tag, "/win_len"},   bus.win_len,   0);
    check_output({tag, "/dly_rst"},   bus.dly_rst,   0);
    check_output({tag, "/dly_ce"},    bus.dly_ce,    0);
    check_output({tag, "/dly_inc"},   bus.dly_inc,   0);
  endtask

  task automatic apply_stimulus(input logic [31:0] mask, input bit glitch);
    pass_mask = mask;
    glitch_en = glitch;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
  endtask

  task automatic run_cal(input vec_t v, input int extra_start_at);
    int  rst_before;
    bit  finished;
    rst_before = rst_pulses;
    apply_stimulus(v.mask, v.glitch);
    check_output({v.name, "/busy_after_start"}, bus.busy, 1);
    check_output({v.name, "/done_cleared"},     bus.done, 0);
    check_output({v.name, "/fail_cleared"},     bus.fail, 0);
    finished = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      if (n == extra_start_at) begin
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
      end
      if (!bus.busy) begin
        finished = 1'b1;
        break;
      end
    end
    check_output({v.name, "/finished"}, finished, 1);
    check_output({v.name, "/done"},      bus.done,      v.exp_done);
    check_output({v.name, "/fail"},      bus.fail,      v.exp_fail);
    check_output({v.name, "/win_start"}, bus.win_start, v.exp_ws);
    check_output({v.name, "/win_len"},   bus.win_len,   v.exp_wl);
    check_output({v.name, "/tap_value"}, bus.tap_value, v.exp_tap);
    check_output({v.name, "/moves"},     ce_after_rst,  v.exp_moves);
    check_output({v.name, "/rst_pulses"}, rst_pulses - rst_before, 2);
    check_range({v.name, "/latency"}, last_rst_cycle - prev_rst_cycle, SWEEP_LAT - 1, SWEEP_LAT + 1);
    check_output({v.name, "/protocol"}, proto_err, 0);
    repeat (3) @(negedge clk);
    #1;
    check_output({v.name, "/sticky_done"}, bus.done, v.exp_done);
    check_output({v.name, "/sticky_fail"}, bus.fail, v.exp_fail);
    check_output({v.name, "/idle_busy"},   bus.busy, 0);
  endtask

  vec_t vecs[9];

  initial begin
    int  p0;
    bit  hit;
    vecs[0] = '{range_mask(10, 20), 1'b0, 1'b1, 1'b0, 10, 11, 15, 15, "win_10_20"};
    vecs[1] = '{range_mask(3, 5),   1'b0, 1'b0, 1'b1,  3,  3,  0,  0, "narrow_3_5"};
    vecs[2] = '{range_mask(2, 5) | range_mask(20, 27), 1'b0, 1'b1, 1'b0, 20, 8, 23, 23, "two_windows"};
    vecs[3] = '{range_mask(0, 3) | range_mask(10, 13), 1'b0, 1'b1, 1'b0,  0, 4,  1,  1, "tie_earliest"};
    vecs[4] = '{32'hFFFF_FFFF,      1'b0, 1'b1, 1'b0,  0, 32, 15, 15, "all_pass"};
    vecs[5] = '{range_mask(8, 20),  1'b1, 1'b1, 1'b0, 13,  8, 16, 16, "glitch_tap12"};
    vecs[6] = '{32'h0000_0000,      1'b0, 1'b0, 1'b1,  0,  0,  0,  0, "none_pass"};
    vecs[7] = '{range_mask(28, 31), 1'b0, 1'b1, 1'b0, 28,  4, 29, 29, "win_at_top"};
    vecs[8] = '{range_mask(0, 1),   1'b0, 1'b0, 1'b1,  0,  2,  0,  0, "short_at_zero"};

    bus.start = 1'b0;
    bus.adc_i = PAT_I;
    bus.adc_q = PAT_Q;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_cal(vecs[i], -1);

    // A start pulse mid-sweep must not restart or lengthen the calibration.
    run_cal('{range_mask(2, 5) | range_mask(20, 27), 1'b0, 1'b1, 1'b0, 20, 8, 23, 23, "restart_ignored"}, 100);

    // Reset while the sweep sits at tap 7.
    apply_stimulus(range_mask(10, 20), 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk); #1;
      if (model_tap == 7) begin
        hit = 1'b1;
        break;
      end
    end
    check_output("midreset/reached_tap7", hit, 1);
    rst = 1'b0;
    @(negedge clk); #1;
    check_all_zero("midreset");
    @(negedge clk);
    p0 = pulse_total;
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check_output("midreset/no_pulses", pulse_total - p0, 0);
    check_output("midreset/idle_busy", bus.busy, 0);
    run_cal('{range_mask(10, 20), 1'b0, 1'b1, 1'b0, 10, 11, 15, 15, "recal_after_reset"}, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
